// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per cycle.
// Optional abort input is compiled in when SLU_ABORT_EN is defined.
module sliced_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SLU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [WIDTH-1:0] w_work_next;
  logic             w_abort;
  logic             w_last;

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       f,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    case (f)
      2'b00:   slice_op = x & y;
      2'b01:   slice_op = x | y;
      2'b10:   slice_op = x ^ y;
      default: slice_op = ~(x | y);
    endcase
  endfunction

  // Only the slice selected by r_idx is recomputed; the rest of the work word passes through.
  for (genvar g = 0; g < N; g++) begin : g_slice
    assign w_work_next[g*SLICE +: SLICE] =
      (r_idx == IW'(g)) ? slice_op(r_op, r_a[g*SLICE +: SLICE], r_b[g*SLICE +: SLICE])
                        : r_work[g*SLICE +: SLICE];
  end

`ifdef SLU_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last = (r_idx == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_work  <= '0;
            r_idx   <= '0;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          // Abort wins over completion, so a final-slice abort never publishes a result.
          if (w_abort) begin
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_work <= w_work_next;
            if (w_last) begin
              r_result <= w_work_next;
              r_zero   <= (w_work_next == '0);
              r_idx    <= '0;
              r_state  <= S_DONE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_BUSY);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Directed-vector bench for sliced_logic_unit: a WIDTH=32/SLICE=8 instance and a
// single-slice (SLICE=WIDTH) instance; abort checks are built when SLU_ABORT_EN is defined.
module tb_sliced_logic_unit;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             start1;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy, done, zero;
  logic [WIDTH-1:0] result;
  logic [1:0]       dbg_state;
  logic             busy1, done1, zero1;
  logic [WIDTH-1:0] result1;
  logic [1:0]       dbg_state1;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sliced_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
`ifdef SLU_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result), .zero(zero), .dbg_state(dbg_state)
  );

  sliced_logic_unit #(.WIDTH(WIDTH), .SLICE(WIDTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .a(a), .b(b),
`ifdef SLU_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .done(done1), .result(result1), .zero(zero1), .dbg_state(dbg_state1)
  );

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE or DONE and follow it to its DONE cycle.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [1:0] vop, input logic [31:0] exp, input bit poke);
    a = va; b = vb; op = vop; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      if (poke && i == 1) begin
        start = 1'b1;
        a = 32'($urandom);
        b = 32'($urandom);
        op = 2'($urandom_range(0, 3));
      end
      if (poke && i == 2) start = 1'b0;
      step();
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp));
    check({tag, "_zero"}, 64'(zero), 64'(exp == 32'd0));
  endtask

  int done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b1; start1 = 1'b1; abort = 1'b0;
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h1234_5678;

    // Reset with start held high.
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    start = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    step();
    step();
    check("post_rst_state", 64'(dbg_state), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    run_op("and", 32'hF0F0_1234, 32'hFF00_FFFF, 2'b00, 32'hF000_1234, 1'b0);
    step();
    check("and_idle_done", 64'(done), 64'd0);
    check("and_hold", 64'(result), 64'hF000_1234);

    run_op("xor_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b0);
    run_op("nor_zero", 32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 32'h0000_0000, 1'b0);
    run_op("or_b2b", 32'h0000_00FF, 32'h0F00_0000, 2'b01, 32'h0F00_00FF, 1'b1);
    run_op("nor", 32'h0F0F_0000, 32'h00F0_0000, 2'b11, 32'hF000_FFFF, 1'b0);
    run_op("or_b2b2", 32'h0000_00FF, 32'h0F00_0000, 2'b01, 32'h0F00_00FF, 1'b0);
    step();
    check("final_idle_state", 64'(dbg_state), 64'd0);
    check("final_hold", 64'(result), 64'h0F00_00FF);

    // Reset on the second BUSY cycle discards the op.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_zero", 64'(zero), 64'd0);
    done_seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (done) done_seen++;
      step();
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // Single-slice instance: done one edge after the start edge.
    a = 32'h1234_5678; b = 32'h0000_0000; op = 2'b01; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("n1_busy", 64'(busy1), 64'd1);
    check("n1_nodone", 64'(done1), 64'd0);
    step();
    check("n1_done", 64'(done1), 64'd1);
    check("n1_result", 64'(result1), 64'h1234_5678);
    check("n1_zero", 64'(zero1), 64'd0);
    step();
    check("n1_idle", 64'(dbg_state1), 64'd0);

`ifdef SLU_ABORT_EN
    run_op("ab_pre", 32'h1234_5678, 32'h0000_0000, 2'b01, 32'h1234_5678, 1'b0);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N - 1; i++) step();
    check("ab_final_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_done", 64'(done), 64'd0);
    check("ab_state", 64'(dbg_state), 64'd0);
    check("ab_result", 64'(result), 64'h1234_5678);
    done_seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      if (done) done_seen++;
      step();
    end
    check("ab_no_done", 64'(done_seen), 64'd0);

    a = 32'h0000_0000; b = 32'h0000_0000; op = 2'b11; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("ab1_busy", 64'(busy1), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab1_busy_lo", 64'(busy1), 64'd0);
    check("ab1_done", 64'(done1), 64'd0);
    check("ab1_result", 64'(result1), 64'h1234_5678);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
